// File: rtl/bin2bcd_module.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock, start/busy/done handshake.
// Optional build macro BIN2BCD_SATURATE_EN clamps out-of-range results to 24'h999999.
module bin2bcd_module #(
  parameter int BIN_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_data,
  output logic             busy,
  output logic             done,
  output logic [23:0]      bcd_data,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam int               CNT_W    = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  // 21 bits so the zero-extension below never needs a zero-width replication.
  localparam logic [20:0]      MAX_DEC  = 21'd999999;

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [23:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [23:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [23:0]      acc_adj;
  logic             in_range_ovf;

  assign in_range_ovf = {{(21-BIN_W){1'b0}}, bin_data} > MAX_DEC;

  // Add-3 correction on every digit that would reach 10 or more after the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 6; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = bin_data;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = in_range_ovf;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Bit 23 of the corrected accumulator is the carry out of digit 5 and is dropped.
        acc_d   = {acc_adj[22:0], shift_q[BIN_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
`ifdef BIN2BCD_SATURATE_EN
        bcd_d = ovf_pend_q ? 24'h999999 : acc_q;
`else
        bcd_d = acc_q;
`endif
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign bcd_data = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_module.sv
// Self-checking bench for bin2bcd_module: vector table, handshake corner cases, and random values
// against a decimal-arithmetic reference model.
module tb_bin2bcd_module;

  localparam int BIN_W = 20;

  logic             clk;
  logic             rst;
  logic             start;
  logic [BIN_W-1:0] bin_data;
  logic             busy;
  logic             done;
  logic [23:0]      bcd_data;
  logic             overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  bin2bcd_module #(.BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_data (bin_data),
    .busy     (busy),
    .done     (done),
    .bcd_data (bcd_data),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits of (v mod 10^6), peeled off with / and %.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] res;
    int unsigned r;
    res = '0;
    r   = v % 1000000;
    for (int d = 0; d < 6; d++) begin
      res[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef BIN2BCD_SATURATE_EN
    if (v > 999999) res = 24'h999999;
`endif
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output bit got, output int cycles, output int busy_n,
                           output bit unstable, input logic [23:0] prev);
    got = 0; cycles = 0; busy_n = 0; unstable = 0;
    while (cycles < 100) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) busy_n++;
      if (bcd_data !== prev) unstable = 1;
      cycles++;
    end
  endtask

  task automatic run_conv(input logic [19:0] v, input logic [23:0] exp_bcd,
                          input logic exp_ovf, input string tag);
    logic [23:0] prev;
    bit got, unstable, digits_ok;
    int cycles, busy_n;
    @(negedge clk);
    prev     = bcd_data;
    start    = 1'b1;
    bin_data = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bin_data = BIN_W'($urandom);
    wait_done(got, cycles, busy_n, unstable, prev);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(BIN_W + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(BIN_W + 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_bcd"}, 32'(bcd_data), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_no_intermediate"}, 32'(unstable), 32'd0);
    digits_ok = 1;
    for (int d = 0; d < 6; d++) if (bcd_data[4*d +: 4] > 4'd9) digits_ok = 0;
    check({tag, "_digits_le9"}, 32'(digits_ok), 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit got, unstable;
    int cycles, busy_n, a0, a1, n_done;
    logic [23:0] seen_bcd;
    int unsigned v;

    rst = 1'b1; start = 1'b0; bin_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd_data), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    vecs.push_back('{bin: 20'd0,       bcd: 24'h000000, ovf: 1'b0});
    vecs.push_back('{bin: 20'd9,       bcd: 24'h000009, ovf: 1'b0});
    vecs.push_back('{bin: 20'd10,      bcd: 24'h000010, ovf: 1'b0});
    vecs.push_back('{bin: 20'd99,      bcd: 24'h000099, ovf: 1'b0});
    vecs.push_back('{bin: 20'd123456,  bcd: 24'h123456, ovf: 1'b0});
    vecs.push_back('{bin: 20'd100000,  bcd: 24'h100000, ovf: 1'b0});
    vecs.push_back('{bin: 20'd500001,  bcd: 24'h500001, ovf: 1'b0});
    vecs.push_back('{bin: 20'd765432,  bcd: 24'h765432, ovf: 1'b0});
    vecs.push_back('{bin: 20'd999999,  bcd: 24'h999999, ovf: 1'b0});
`ifdef BIN2BCD_SATURATE_EN
    vecs.push_back('{bin: 20'd1000000, bcd: 24'h999999, ovf: 1'b1});
    vecs.push_back('{bin: 20'd1048575, bcd: 24'h999999, ovf: 1'b1});
`else
    vecs.push_back('{bin: 20'd1000000, bcd: 24'h000000, ovf: 1'b1});
    vecs.push_back('{bin: 20'd1048575, bcd: 24'h048575, ovf: 1'b1});
`endif
    foreach (vecs[i]) run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));

    // Back-to-back with start held high: second accept lands one cycle after done.
    @(negedge clk);
    start = 1'b1; bin_data = 20'd123456;
    @(posedge clk);
    #1;
    a0 = cyc;
    bin_data = 20'd999999;
    wait_done(got, cycles, busy_n, unstable, bcd_data);
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_bcd", 32'(bcd_data), 32'h123456);
    check("b2b_first_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    a1 = cyc;
    start = 1'b0;
    check("b2b_accept_spacing", 32'(a1 - a0), 32'(BIN_W + 2));
    @(negedge clk);
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_done(got, cycles, busy_n, unstable, bcd_data);
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_second_bcd", 32'(bcd_data), 32'h999999);
    check("b2b_second_ovf", 32'(overflow), 32'd0);

    // A start pulse during a conversion must be ignored.
    @(negedge clk);
    start = 1'b1; bin_data = 20'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; bin_data = 20'd555;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; seen_bcd = '0;
    repeat (45) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        seen_bcd = bcd_data;
      end
    end
    check("ignore_done_count", 32'(n_done), 32'd1);
    check("ignore_bcd", 32'(seen_bcd), 32'h000100);

    // Reset mid-conversion: outputs clear, no done, then a fresh conversion works.
    @(negedge clk);
    start = 1'b1; bin_data = 20'd654321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd_data), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run_conv(20'd42, 24'h000042, 1'b0, "post_rst");

    // Random values across the full input range against the decimal model.
    for (int i = 0; i < 150; i++) begin
      v = (i % 4 == 0) ? $urandom_range(1048575, 999000) : $urandom_range(999999, 0);
      run_conv(20'(v), ref_bcd(v), (v > 999999), $sformatf("rand%0d_v%0d", i, v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
